// File: rtl/ysram_arbiter.sv
// Y SRAM arbiter: one single-port row SRAM shared by row reads and 48-bit lane read-modify-writes.
// Define YSRAM_ARB_RR_EN for round-robin arbitration; default is fixed write-over-read priority.

module ysram_lane_merge #(
  parameter int VEC_W = 48,
  parameter int LANE  = 0
) (
  input  logic [VEC_W-1:0] oldLane,
  input  logic [VEC_W-1:0] newLane,
  input  logic [2:0]       slot,
  output logic [VEC_W-1:0] mergedLane
);
  assign mergedLane = (slot == 3'(LANE)) ? newLane : oldLane;
endmodule

module ysram_arbiter #(
  parameter int NUM_LANES = 5,
  parameter int VEC_W     = 48,
  parameter int ADDR_W    = 11,
  parameter int ROW_W     = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [ROW_W-1:0]  rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_slot,
  input  logic [VEC_W-1:0]  wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic              busy
);
  localparam int LANE_BITS = NUM_LANES * VEC_W;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR_RD, WR_WAIT, WR_WR} state_t;

  state_t             state, nextState;
  logic               lastWasWr, nextLastWasWr;
  logic [2:0]         slotQ, nextSlotQ;
  logic [VEC_W-1:0]   dataQ, nextDataQ;
  logic               nRdGnt, nRdValid, nWrGnt, nWrDone, nWrErr, nMemEn, nMemWen;
  logic [ROW_W-1:0]   nRdData, nMemWdata;
  logic [ADDR_W-1:0]  nMemAddr;
  logic               wrWins;

  logic [NUM_LANES-1:0][VEC_W-1:0] oldLanes, mergedLanes;

  assign oldLanes = mem_rdata[LANE_BITS-1:0];

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    ysram_lane_merge #(.VEC_W(VEC_W), .LANE(i)) uMerge (
      .oldLane    (oldLanes[i]),
      .newLane    (dataQ),
      .slot       (slotQ),
      .mergedLane (mergedLanes[i])
    );
  end

`ifdef YSRAM_ARB_RR_EN
  // lastWasWr resets to 0, so the first contended grant goes to the write
  assign wrWins = ~lastWasWr;
`else
  assign wrWins = 1'b1;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    nextState     = state;
    nextLastWasWr = lastWasWr;
    nextSlotQ     = slotQ;
    nextDataQ     = dataQ;
    nRdGnt        = 1'b0;
    nRdValid      = 1'b0;
    nRdData       = rd_data;
    nWrGnt        = 1'b0;
    nWrDone       = 1'b0;
    nWrErr        = 1'b0;
    nMemEn        = 1'b0;
    nMemWen       = 1'b0;
    nMemAddr      = mem_addr;
    nMemWdata     = mem_wdata;
    case (state)
      IDLE: begin
        if (wr_req && (!rd_req || wrWins)) begin
          nWrGnt        = 1'b1;
          nextLastWasWr = 1'b1;
          if (wr_slot <= 3'(NUM_LANES - 1)) begin
            nextState = WR_RD;
            nextSlotQ = wr_slot;
            nextDataQ = wr_data;
            nMemAddr  = wr_addr;
            nMemEn    = 1'b1;
          end else begin
            nWrErr = 1'b1;
          end
        end else if (rd_req) begin
          nRdGnt        = 1'b1;
          nextLastWasWr = 1'b0;
          nextState     = RD_ISSUE;
          nMemAddr      = rd_addr;
          nMemEn        = 1'b1;
        end
      end
      RD_ISSUE: nextState = RD_DATA;
      RD_DATA: begin
        nRdData   = mem_rdata;
        nRdValid  = 1'b1;
        nextState = IDLE;
      end
      WR_RD: nextState = WR_WAIT;
      WR_WAIT: begin
        // top pad bits above the lanes ride through untouched
        nMemWdata = {mem_rdata[ROW_W-1:LANE_BITS], mergedLanes};
        nMemEn    = 1'b1;
        nMemWen   = 1'b1;
        nextState = WR_WR;
      end
      WR_WR: begin
        nWrDone   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lastWasWr <= 1'b0;
      slotQ     <= '0;
      dataQ     <= '0;
      rd_gnt    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_gnt    <= 1'b0;
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nextState;
      lastWasWr <= nextLastWasWr;
      slotQ     <= nextSlotQ;
      dataQ     <= nextDataQ;
      rd_gnt    <= nRdGnt;
      rd_valid  <= nRdValid;
      rd_data   <= nRdData;
      wr_gnt    <= nWrGnt;
      wr_done   <= nWrDone;
      wr_err    <= nWrErr;
      mem_en    <= nMemEn;
      mem_wen   <= nMemWen;
      mem_addr  <= nMemAddr;
      mem_wdata <= nMemWdata;
    end
  end
endmodule

// File: tb/tb_ysram_arbiter.sv
// Directed bench for ysram_arbiter with a one-cycle-latency row SRAM model.
// Expected contention order follows YSRAM_ARB_RR_EN as compiled.

module tb_ysram_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req = 1'b0;
  logic [10:0]  rd_addr = '0;
  logic         rd_gnt, rd_valid;
  logic [255:0] rd_data;
  logic         wr_req = 1'b0;
  logic [10:0]  wr_addr = '0;
  logic [2:0]   wr_slot = '0;
  logic [47:0]  wr_data = '0;
  logic         wr_gnt, wr_done, wr_err;
  logic         mem_en, mem_wen;
  logic [10:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [255:0] mem [0:2047];
  logic         bdEn = 1'b0;
  logic [10:0]  bdAddr = '0;
  logic [255:0] bdData = '0;

  ysram_arbiter dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_slot(wr_slot), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_err(wr_err),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // SRAM model; backdoor preload shares the same process
  always @(posedge clock) begin
    if (bdEn) mem[bdAddr] <= bdData;
    else if (mem_en) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [255:0] d);
    bdEn = 1'b1; bdAddr = a; bdData = d;
    tick();
    bdEn = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [255:0] patP, patQ, patR, expRow;
  logic [31:0]  order, expOrder;
  int           nG, firstC, lastC;

  initial begin
    patP = {8{32'hDEAD_BEEF}} ^ {64{4'h3}};
    patQ = {8{32'h0F1E_2D3C}};
    patR = {8{32'hA5A5_5A5A}};

    // reset state and SRAM preload while reset is held
    wr_req = 1'b1; rd_req = 1'b1; wr_slot = 3'd1;
    preload(11'h005, patP);
    preload(11'h010, '1);
    preload(11'h020, patR);
    preload(11'h040, patQ);
    chk("rst_rd_gnt",   256'(rd_gnt), 256'(0));
    chk("rst_wr_gnt",   256'(wr_gnt), 256'(0));
    chk("rst_mem_en",   256'(mem_en), 256'(0));
    chk("rst_busy",     256'(busy), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_wdata",    mem_wdata, '0);
    chk("rst_rd_data",  rd_data, '0);
    wr_req = 1'b0; rd_req = 1'b0;
    reset = 1'b0;

    // read of row 0x005
    rd_req = 1'b1; rd_addr = 11'h005;
    tick();
    chk("rd_e0_gnt",  256'(rd_gnt), 256'(1));
    chk("rd_e0_en",   256'({mem_en, mem_wen}), 256'(2'b10));
    chk("rd_e0_addr", 256'(mem_addr), 256'(11'h005));
    chk("rd_e0_busy", 256'(busy), 256'(1));
    rd_req = 1'b0;
    tick();
    chk("rd_e1", 256'({rd_gnt, mem_en, rd_valid}), 256'(3'b000));
    tick();
    chk("rd_e2_valid", 256'(rd_valid), 256'(1));
    chk("rd_e2_data",  rd_data, patP);
    chk("rd_e2_busy",  256'(busy), 256'(0));
    tick();
    chk("rd_e3_valid", 256'(rd_valid), 256'(0));

    // write slot 2 into all-ones row 0x010
    expRow = '1;
    expRow[143:96] = 48'h123456ABCDEF;
    wr_req = 1'b1; wr_addr = 11'h010; wr_slot = 3'd2; wr_data = 48'h123456ABCDEF;
    tick();
    chk("wr_e0", 256'({wr_gnt, wr_err, mem_en, mem_wen}), 256'(4'b1010));
    chk("wr_e0_addr", 256'(mem_addr), 256'(11'h010));
    wr_req = 1'b0;
    tick();
    chk("wr_e1", 256'({wr_gnt, mem_en, wr_done}), 256'(3'b000));
    tick();
    chk("wr_e2_en", 256'({mem_en, mem_wen, wr_done}), 256'(3'b110));
    chk("wr_e2_wdata", mem_wdata, expRow);
    tick();
    chk("wr_e3", 256'({wr_done, mem_en, mem_wen, busy}), 256'(4'b1000));
    chk("wr_row10", mem[11'h010], expRow);
    chk("wr_hold_wdata", mem_wdata, expRow);

    // boundary lane: slot 4, pad bits [255:240] preserved
    expRow = patR;
    expRow[239:192] = 48'hFEDCBA987654;
    wr_req = 1'b1; wr_addr = 11'h020; wr_slot = 3'd4; wr_data = 48'hFEDCBA987654;
    tick();
    wr_req = 1'b0;
    tick(); tick();
    chk("wr4_wdata", mem_wdata, expRow);
    tick();
    chk("wr4_done", 256'(wr_done), 256'(1));
    chk("wr4_row", mem[11'h020], expRow);

    // bad slot
    wr_req = 1'b1; wr_addr = 11'h011; wr_slot = 3'd6; wr_data = 48'h1;
    tick();
    chk("bad_e0", 256'({wr_gnt, wr_err, mem_en, busy}), 256'(4'b1100));
    wr_req = 1'b0;
    tick();
    chk("bad_e1", 256'({wr_gnt, wr_err, mem_en, busy}), 256'(4'b0000));

    // reset during WR_WAIT, then a normal write to the same row
    wr_req = 1'b1; wr_addr = 11'h040; wr_slot = 3'd1; wr_data = 48'h111111222222;
    tick();
    wr_req = 1'b0;
    tick();
    chk("rw_pre_busy", 256'(busy), 256'(1));
    #2 reset = 1'b1;
    #1;
    chk("rw_async_busy", 256'(busy), 256'(0));
    chk("rw_async_outs", 256'({mem_en, mem_wen, wr_done, wr_gnt, rd_valid}), 256'(0));
    chk("rw_async_rd_data", rd_data, '0);
    chk("rw_async_wdata", mem_wdata, '0);
    tick();
    chk("rw_rst_done", 256'({wr_done, mem_en, mem_wen}), 256'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("rw_post_done", 256'({wr_done, mem_en, busy}), 256'(0));
    chk("rw_row_untouched", mem[11'h040], patQ);
    expRow = patQ;
    expRow[95:48] = 48'h333333444444;
    wr_req = 1'b1; wr_addr = 11'h040; wr_slot = 3'd1; wr_data = 48'h333333444444;
    tick();
    chk("rw2_gnt", 256'(wr_gnt), 256'(1));
    wr_req = 1'b0;
    tick(); tick(); tick();
    chk("rw2_done", 256'(wr_done), 256'(1));
    chk("rw2_row", mem[11'h040], expRow);

    // contention from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_req = 1'b1; rd_addr = 11'h005;
    wr_req = 1'b1; wr_addr = 11'h030; wr_slot = 3'd0; wr_data = 48'hABCDEF012345;
    order = '0; nG = 0; firstC = 0; lastC = 0;
    for (int i = 0; i < 40 && nG < 4; i++) begin
      tick();
      if (wr_gnt) order = {order[23:0], 8'h57};
      if (rd_gnt) order = {order[23:0], 8'h52};
      if (wr_gnt || rd_gnt) begin
        if (nG == 0) firstC = i;
        lastC = i;
        nG++;
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
`ifdef YSRAM_ARB_RR_EN
    expOrder = "WRWR";
    chk("cont_span", 256'(lastC - firstC), 256'(11));
`else
    expOrder = "WWWW";
    chk("cont_span", 256'(lastC - firstC), 256'(12));
`endif
    chk("cont_grants", 256'(nG), 256'(4));
    chk("cont_order", 256'(order), 256'(expOrder));
    for (int i = 0; i < 5; i++) tick();
    chk("cont_idle", 256'(busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
